multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum wait cycles for mem_ready in any memory state.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports op  in  6 and funct  in  6: instruction fields [31:26] and [5:0] from the instruction register.
REQ-005 SHALL have ports zero  in  1 (ALU zero flag) and mem_ready  in  1 (memory completes the access this cycle).
REQ-006 SHALL have outputs pcen, irwrite, memread, memwrite, iord, regwrite, regdst, memtoreg, alusrca (1 bit each), alusrcb  2, pcsrc  2, alucontrol  3.
REQ-007 SHALL have outputs bus_err  1 (sticky timeout flag), halted  1, and state  4 (debug view of current state).

Function
REQ-008 SHALL be a Moore FSM: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, HALT=12; codes 13-15 go to HALT.
REQ-009 SHALL, in every state, drive any control output not listed below to 0; alucontrol default 010 (add).
REQ-010 FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, pcsrc=00; irwrite=pcen=mem_ready; advance to DECODE only when mem_ready=1.
REQ-011 DECODE: alusrca=0, alusrcb=11 (branch target precompute); next by op: 100011/101011->MEMADR, 000000->EXECUTE, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP, any other op->HALT.
REQ-012 DECODE SHALL send op=000000 with funct outside {100000,100010,100100,100101,101010} to HALT.
REQ-013 MEMADR: alusrca=1, alusrcb=10; next MEMREAD for lw, MEMWRITE for sw.
REQ-014 MEMREAD: iord=1, memread=1; MEMWRITE: iord=1, memwrite=1; both hold until mem_ready=1, then MEMREAD->MEMWB, MEMWRITE->FETCH.
REQ-015 MEMWB: regdst=0, memtoreg=1, regwrite=1; next FETCH.
REQ-016 EXECUTE: alusrca=1, alusrcb=00, alucontrol add=010, sub=110, and=000, or=001, slt=111 from funct; next ALUWB.
REQ-017 ALUWB: regdst=1, memtoreg=0, regwrite=1; next FETCH.
REQ-018 BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcen=zero for beq; next FETCH.
REQ-019 ADDIEX: alusrca=1, alusrcb=10, add, next ADDIWB; ADDIWB: regdst=0, memtoreg=0, regwrite=1, next FETCH.
REQ-020 JUMP: pcsrc=10, pcen=1; next FETCH.
REQ-021 HALT: all enables 0, halted=1; remains until reset.
REQ-022 SHALL keep a wait counter, cleared on entry to FETCH/MEMREAD/MEMWRITE, incremented each cycle there with mem_ready=0.
REQ-023 When the counter equals TIMEOUT and mem_ready=0, next state SHALL be HALT and bus_err SHALL set; mem_ready=1 on that same cycle takes priority (normal completion).
REQ-024 Counter SHALL saturate at TIMEOUT, never wrap; TIMEOUT=0 means any wait cycle halts.
REQ-025 state output SHALL equal the current state code.

Reset
REQ-026 reset=0 SHALL immediately force state=FETCH, counter=0, bus_err=0, halted=0, independent of clk.
REQ-027 Reset mid-access (e.g. during MEMWRITE) SHALL drop memwrite/regwrite/pcen at once; first post-reset edge samples FETCH outputs.

Configuration
REQ-028 Macro MULTICYCLE_CTRL_BNE_EN defined: op=000101 goes DECODE->BRANCH with pcen=~zero, otherwise as beq.
REQ-029 Macro undefined: op=000101 SHALL go DECODE->HALT like any unsupported opcode.

Verification
REQ-030 lw, mem_ready=1 always -> states 0,1,2,3,4,0; regwrite=1, memtoreg=1 only in state 4.
REQ-031 R-type funct=101010 -> 0,1,6,7,0; alucontrol=111 in state 6, regdst=1 in state 7.
REQ-032 beq zero=1 -> pcen=1, pcsrc=01 in state 8; zero=0 -> pcen=0; bne (macro defined) gives opposite.
REQ-033 FETCH with mem_ready low 3 cycles, TIMEOUT=15 -> stays 0, irwrite=0, then one-cycle irwrite=1 on ready.
REQ-034 sw with mem_ready held 0 -> after 16 cycles in state 5: state 12, bus_err=1, halted=1, memwrite=0; reset low clears all.
REQ-035 op=111111 -> HALT after DECODE; reset pulse during MEMREAD -> memread stays 1 as FETCH, iord=0 immediately.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM with memory-wait timeout and sticky bus error.
// Optional bne support is enabled by defining MULTICYCLE_CTRL_BNE_EN.
module multicycle_ctrl #(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcen,
   output logic       irwrite,
   output logic       memread,
   output logic       memwrite,
   output logic       iord,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic       bus_err,
   output logic       halted,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEX   = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11,
      S_HALT     = 4'd12
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MULTICYCLE_CTRL_BNE_EN
   localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

   state_t        cur;
   logic [CW-1:0] cnt;
   logic          funct_ok;
   logic          wait_hit;

   assign funct_ok = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                     (funct == F_OR)  || (funct == F_SLT);
   // Completion on the last allowed cycle wins, so a timeout needs mem_ready low.
   assign wait_hit = !mem_ready && (cnt == TMAX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur     <= S_FETCH;
         cnt     <= '0;
         bus_err <= 1'b0;
      end else begin
         cnt <= '0;
         case (cur)
            S_FETCH, S_MEMREAD, S_MEMWRITE: begin
               if (mem_ready) begin
                  case (cur)
                     S_FETCH:   cur <= S_DECODE;
                     S_MEMREAD: cur <= S_MEMWB;
                     default:   cur <= S_FETCH;
                  endcase
               end else if (wait_hit) begin
                  cur     <= S_HALT;
                  cnt     <= cnt;
                  bus_err <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DECODE: begin
               case (op)
                  OP_LW, OP_SW: cur <= S_MEMADR;
                  OP_R:         cur <= funct_ok ? S_EXECUTE : S_HALT;
                  OP_BEQ:       cur <= S_BRANCH;
`ifdef MULTICYCLE_CTRL_BNE_EN
                  OP_BNE:       cur <= S_BRANCH;
`endif
                  OP_ADDI:      cur <= S_ADDIEX;
                  OP_J:         cur <= S_JUMP;
                  default:      cur <= S_HALT;
               endcase
            end
            S_MEMADR:  cur <= (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_EXECUTE: cur <= S_ALUWB;
            S_ADDIEX:  cur <= S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: cur <= S_FETCH;
            S_HALT:    cur <= S_HALT;
            default:   cur <= S_HALT;
         endcase
      end
   end

   // Outputs decode the registered state, so an async reset shows FETCH outputs at once.
   always_comb begin
      pcen       = 1'b0;
      irwrite    = 1'b0;
      memread    = 1'b0;
      memwrite   = 1'b0;
      iord       = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = 3'b010;
      case (cur)
         S_FETCH: begin
            memread = 1'b1;
            alusrcb = 2'b01;
            irwrite = mem_ready;
            pcen    = mem_ready;
         end
         S_DECODE:   alusrcb = 2'b11;
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMREAD: begin
            iord    = 1'b1;
            memread = 1'b1;
         end
         S_MEMWRITE: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         S_MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         S_EXECUTE: begin
            alusrca = 1'b1;
            case (funct)
               F_SUB:   alucontrol = 3'b110;
               F_AND:   alucontrol = 3'b000;
               F_OR:    alucontrol = 3'b001;
               F_SLT:   alucontrol = 3'b111;
               default: alucontrol = 3'b010;
            endcase
         end
         S_ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         S_BRANCH: begin
            alusrca    = 1'b1;
            alucontrol = 3'b110;
            pcsrc      = 2'b01;
`ifdef MULTICYCLE_CTRL_BNE_EN
            pcen       = (op == OP_BNE) ? ~zero : zero;
`else
            pcen       = zero;
`endif
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_ADDIWB:   regwrite = 1'b1;
         S_JUMP: begin
            pcsrc = 2'b10;
            pcen  = 1'b1;
         end
         default: ;
      endcase
   end

   assign halted = (cur == S_HALT);
   assign state  = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed table-driven bench for multicycle_ctrl, plus hand sequences for
// timeouts, async reset mid-access and a TIMEOUT=0 instance.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;

   logic       pcen, irwrite, memread, memwrite, iord, regwrite, regdst, memtoreg, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic       bus_err, halted;
   logic [3:0] state;

   logic [15:0] z_misc;
   logic        z_bus_err, z_halted;
   logic [3:0]  z_state;

   int checks = 0;
   int errors = 0;

   multicycle_ctrl #(.TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .pcen(pcen), .irwrite(irwrite), .memread(memread), .memwrite(memwrite), .iord(iord),
      .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
      .bus_err(bus_err), .halted(halted), .state(state)
   );

   multicycle_ctrl #(.TIMEOUT(0)) dut0 (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .pcen(z_misc[0]), .irwrite(z_misc[1]), .memread(z_misc[2]), .memwrite(z_misc[3]),
      .iord(z_misc[4]), .regwrite(z_misc[5]), .regdst(z_misc[6]), .memtoreg(z_misc[7]),
      .alusrca(z_misc[8]), .alusrcb(z_misc[10:9]), .pcsrc(z_misc[12:11]),
      .alucontrol(z_misc[15:13]), .bus_err(z_bus_err), .halted(z_halted), .state(z_state)
   );

   // Control word: pcen irwrite memread memwrite iord regwrite regdst memtoreg alusrca
   //               alusrcb[2] pcsrc[2] alucontrol[3] bus_err halted
   logic [17:0] act_w, z_w;
   assign act_w = {pcen, irwrite, memread, memwrite, iord, regwrite, regdst, memtoreg, alusrca,
                   alusrcb, pcsrc, alucontrol, bus_err, halted};
   assign z_w   = {z_misc[0], z_misc[1], z_misc[2], z_misc[3], z_misc[4], z_misc[5], z_misc[6],
                   z_misc[7], z_misc[8], z_misc[10:9], z_misc[12:11], z_misc[15:13],
                   z_bus_err, z_halted};

   localparam logic [17:0] W_FETCH_RDY  = {1'b1, 1'b1, 1'b1, 6'b0, 2'b01, 2'b00, 3'b010, 2'b00};
   localparam logic [17:0] W_FETCH_WAIT = {1'b0, 1'b0, 1'b1, 6'b0, 2'b01, 2'b00, 3'b010, 2'b00};
   localparam logic [17:0] W_DECODE     = {9'b0, 2'b11, 2'b00, 3'b010, 2'b00};
   localparam logic [17:0] W_MEMADR     = {8'b0, 1'b1, 2'b10, 2'b00, 3'b010, 2'b00};
   localparam logic [17:0] W_MEMREAD    = {2'b00, 1'b1, 1'b0, 1'b1, 4'b0, 2'b00, 2'b00, 3'b010, 2'b00};
   localparam logic [17:0] W_MEMWRITE   = {3'b000, 1'b1, 1'b1, 4'b0, 2'b00, 2'b00, 3'b010, 2'b00};
   localparam logic [17:0] W_MEMWB      = {5'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 3'b010, 2'b00};
   localparam logic [17:0] W_ALUWB      = {5'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 3'b010, 2'b00};
   localparam logic [17:0] W_BR_T       = {1'b1, 7'b0, 1'b1, 2'b00, 2'b01, 3'b110, 2'b00};
   localparam logic [17:0] W_BR_N       = {1'b0, 7'b0, 1'b1, 2'b00, 2'b01, 3'b110, 2'b00};
   localparam logic [17:0] W_ADDIEX     = {8'b0, 1'b1, 2'b10, 2'b00, 3'b010, 2'b00};
   localparam logic [17:0] W_ADDIWB     = {5'b0, 1'b1, 3'b000, 2'b00, 2'b00, 3'b010, 2'b00};
   localparam logic [17:0] W_JUMP       = {1'b1, 8'b0, 2'b00, 2'b10, 3'b010, 2'b00};
   localparam logic [17:0] W_HALT       = {9'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b1};
   localparam logic [17:0] W_HALT_ERR   = {9'b0, 2'b00, 2'b00, 3'b010, 1'b1, 1'b1};

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J = 6'b000010, OP_BAD = 6'b111111;
   localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
   localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  funct;
      logic        zero;
      logic        mr;
      logic [3:0]  st;
      logic [17:0] w;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [5:0] o, input logic [5:0] f, input logic z,
                               input logic m, input logic [3:0] s, input logic [17:0] w);
      vec_t v;
      v.op = o; v.funct = f; v.zero = z; v.mr = m; v.st = s; v.w = w;
      return v;
   endfunction

   function automatic logic [17:0] w_exec(input logic [2:0] alu);
      return {8'b0, 1'b1, 2'b00, 2'b00, alu, 2'b00};
   endfunction

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Inputs applied just after a negedge; outputs checked 1 ns later.
   task automatic step(input vec_t v, input string tag);
      op = v.op; funct = v.funct; zero = v.zero; mem_ready = v.mr;
      #1;
      chk($sformatf("%s state", tag), {28'b0, state}, {28'b0, v.st});
      chk($sformatf("%s ctl", tag), {14'b0, act_w}, {14'b0, v.w});
      @(negedge clk);
   endtask

   initial begin
      op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0; reset = 1'b0;
      #3;
      chk("reset state", {28'b0, state}, 32'd0);
      chk("reset ctl", {14'b0, act_w}, {14'b0, W_FETCH_WAIT});

      // lw
      tbl.push_back(mk(OP_LW, 6'd0, 1'b0, 1'b1, 4'd0, W_FETCH_RDY));
      tbl.push_back(mk(OP_LW, 6'd0, 1'b0, 1'b1, 4'd1, W_DECODE));
      tbl.push_back(mk(OP_LW, 6'd0, 1'b0, 1'b1, 4'd2, W_MEMADR));
      tbl.push_back(mk(OP_LW, 6'd0, 1'b0, 1'b1, 4'd3, W_MEMREAD));
      tbl.push_back(mk(OP_LW, 6'd0, 1'b0, 1'b1, 4'd4, W_MEMWB));
      // R-type slt, add, sub, and, or
      tbl.push_back(mk(OP_R, F_SLT, 1'b0, 1'b1, 4'd0, W_FETCH_RDY));
      tbl.push_back(mk(OP_R, F_SLT, 1'b0, 1'b1, 4'd1, W_DECODE));
      tbl.push_back(mk(OP_R, F_SLT, 1'b0, 1'b1, 4'd6, w_exec(3'b111)));
      tbl.push_back(mk(OP_R, F_SLT, 1'b0, 1'b1, 4'd7, W_ALUWB));
      tbl.push_back(mk(OP_R, F_ADD, 1'b0, 1'b1, 4'd0, W_FETCH_RDY));
      tbl.push_back(mk(OP_R, F_ADD, 1'b0, 1'b1, 4'd1, W_DECODE));
      tbl.push_back(mk(OP_R, F_ADD, 1'b0, 1'b1, 4'd6, w_exec(3'b010)));
      tbl.push_back(mk(OP_R, F_ADD, 1'b0, 1'b1, 4'd7, W_ALUWB));
      tbl.push_back(mk(OP_R, F_SUB, 1'b0, 1'b1, 4'd0, W_FETCH_RDY));
      tbl.push_back(mk(OP_R, F_SUB, 1'b0, 1'b1, 4'd1, W_DECODE));
      tbl.push_back(mk(OP_R, F_SUB, 1'b0, 1'b1, 4'd6, w_exec(3'b110)));
      tbl.push_back(mk(OP_R, F_SUB, 1'b0, 1'b1, 4'd7, W_ALUWB));
      tbl.push_back(mk(OP_R, F_AND, 1'b0, 1'b1, 4'd0, W_FETCH_RDY));
      tbl.push_back(mk(OP_R, F_AND, 1'b0, 1'b1, 4'd1, W_DECODE));
      tbl.push_back(mk(OP_R, F_AND, 1'b0, 1'b1, 4'd6, w_exec(3'b000)));
      tbl.push_back(mk(OP_R, F_AND, 1'b0, 1'b1, 4'd7, W_ALUWB));
      tbl.push_back(mk(OP_R, F_OR, 1'b0, 1'b1, 4'd0, W_FETCH_RDY));
      tbl.push_back(mk(OP_R, F_OR, 1'b0, 1'b1, 4'd1, W_DECODE));
      tbl.push_back(mk(OP_R, F_OR, 1'b0, 1'b1, 4'd6, w_exec(3'b001)));
      tbl.push_back(mk(OP_R, F_OR, 1'b0, 1'b1, 4'd7, W_ALUWB));
      // sw
      tbl.push_back(mk(OP_SW, 6'd0, 1'b0, 1'b1, 4'd0, W_FETCH_RDY));
      tbl.push_back(mk(OP_SW, 6'd0, 1'b0, 1'b1, 4'd1, W_DECODE));
      tbl.push_back(mk(OP_SW, 6'd0, 1'b0, 1'b1, 4'd2, W_MEMADR));
      tbl.push_back(mk(OP_SW, 6'd0, 1'b0, 1'b1, 4'd5, W_MEMWRITE));
      // beq taken / not taken
      tbl.push_back(mk(OP_BEQ, 6'd0, 1'b1, 1'b1, 4'd0, W_FETCH_RDY));
      tbl.push_back(mk(OP_BEQ, 6'd0, 1'b1, 1'b1, 4'd1, W_DECODE));
      tbl.push_back(mk(OP_BEQ, 6'd0, 1'b1, 1'b1, 4'd8, W_BR_T));
      tbl.push_back(mk(OP_BEQ, 6'd0, 1'b0, 1'b1, 4'd0, W_FETCH_RDY));
      tbl.push_back(mk(OP_BEQ, 6'd0, 1'b0, 1'b1, 4'd1, W_DECODE));
      tbl.push_back(mk(OP_BEQ, 6'd0, 1'b0, 1'b1, 4'd8, W_BR_N));
      // addi, j
      tbl.push_back(mk(OP_ADDI, 6'd0, 1'b0, 1'b1, 4'd0, W_FETCH_RDY));
      tbl.push_back(mk(OP_ADDI, 6'd0, 1'b0, 1'b1, 4'd1, W_DECODE));
      tbl.push_back(mk(OP_ADDI, 6'd0, 1'b0, 1'b1, 4'd9, W_ADDIEX));
      tbl.push_back(mk(OP_ADDI, 6'd0, 1'b0, 1'b1, 4'd10, W_ADDIWB));
      tbl.push_back(mk(OP_J, 6'd0, 1'b0, 1'b1, 4'd0, W_FETCH_RDY));
      tbl.push_back(mk(OP_J, 6'd0, 1'b0, 1'b1, 4'd1, W_DECODE));
      tbl.push_back(mk(OP_J, 6'd0, 1'b0, 1'b1, 4'd11, W_JUMP));
      // lw with two memory wait cycles
      tbl.push_back(mk(OP_LW, 6'd0, 1'b0, 1'b1, 4'd0, W_FETCH_RDY));
      tbl.push_back(mk(OP_LW, 6'd0, 1'b0, 1'b1, 4'd1, W_DECODE));
      tbl.push_back(mk(OP_LW, 6'd0, 1'b0, 1'b1, 4'd2, W_MEMADR));
      tbl.push_back(mk(OP_LW, 6'd0, 1'b0, 1'b0, 4'd3, W_MEMREAD));
      tbl.push_back(mk(OP_LW, 6'd0, 1'b0, 1'b0, 4'd3, W_MEMREAD));
      tbl.push_back(mk(OP_LW, 6'd0, 1'b0, 1'b1, 4'd3, W_MEMREAD));
      tbl.push_back(mk(OP_LW, 6'd0, 1'b0, 1'b1, 4'd4, W_MEMWB));
      // fetch stalls 3 cycles, then unsupported opcode halts
      tbl.push_back(mk(OP_BAD, 6'd0, 1'b0, 1'b0, 4'd0, W_FETCH_WAIT));
      tbl.push_back(mk(OP_BAD, 6'd0, 1'b0, 1'b0, 4'd0, W_FETCH_WAIT));
      tbl.push_back(mk(OP_BAD, 6'd0, 1'b0, 1'b0, 4'd0, W_FETCH_WAIT));
      tbl.push_back(mk(OP_BAD, 6'd0, 1'b0, 1'b1, 4'd0, W_FETCH_RDY));
      tbl.push_back(mk(OP_BAD, 6'd0, 1'b0, 1'b1, 4'd1, W_DECODE));
      tbl.push_back(mk(OP_BAD, 6'd0, 1'b0, 1'b1, 4'd12, W_HALT));
      tbl.push_back(mk(OP_BAD, 6'd0, 1'b0, 1'b0, 4'd12, W_HALT));

      do_reset();
      foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

      // sw with memory never ready: 16 cycles in MEMWRITE, then HALT with bus_err
      do_reset();
      step(mk(OP_SW, 6'd0, 1'b0, 1'b1, 4'd0, W_FETCH_RDY), "to fetch");
      step(mk(OP_SW, 6'd0, 1'b0, 1'b1, 4'd1, W_DECODE), "to decode");
      step(mk(OP_SW, 6'd0, 1'b0, 1'b1, 4'd2, W_MEMADR), "to memadr");
      for (int k = 0; k < 16; k++) step(mk(OP_SW, 6'd0, 1'b0, 1'b0, 4'd5, W_MEMWRITE), $sformatf("to wait%0d", k));
      step(mk(OP_SW, 6'd0, 1'b0, 1'b0, 4'd12, W_HALT_ERR), "to halt");
      step(mk(OP_SW, 6'd0, 1'b0, 1'b1, 4'd12, W_HALT_ERR), "to halt sticky");
      reset = 1'b0;
      #1;
      chk("to reset state", {28'b0, state}, 32'd0);
      chk("to reset ctl", {14'b0, act_w}, {14'b0, W_FETCH_RDY});

      // fetch ready on the final allowed cycle completes normally
      do_reset();
      for (int k = 0; k < 15; k++) step(mk(OP_J, 6'd0, 1'b0, 1'b0, 4'd0, W_FETCH_WAIT), $sformatf("edge wait%0d", k));
      step(mk(OP_J, 6'd0, 1'b0, 1'b1, 4'd0, W_FETCH_RDY), "edge ready");
      step(mk(OP_J, 6'd0, 1'b0, 1'b1, 4'd1, W_DECODE), "edge decode");
      step(mk(OP_J, 6'd0, 1'b0, 1'b1, 4'd11, W_JUMP), "edge jump");

      // async reset during MEMWRITE drops memwrite immediately
      do_reset();
      step(mk(OP_SW, 6'd0, 1'b0, 1'b1, 4'd0, W_FETCH_RDY), "rw fetch");
      step(mk(OP_SW, 6'd0, 1'b0, 1'b1, 4'd1, W_DECODE), "rw decode");
      step(mk(OP_SW, 6'd0, 1'b0, 1'b1, 4'd2, W_MEMADR), "rw memadr");
      step(mk(OP_SW, 6'd0, 1'b0, 1'b0, 4'd5, W_MEMWRITE), "rw memwrite");
      reset = 1'b0;
      #1;
      chk("rw reset ctl", {14'b0, act_w}, {14'b0, W_FETCH_WAIT});
      #1 reset = 1'b1;

      // async reset pulse during MEMREAD: FETCH outputs at once, FETCH sampled at next edge
      do_reset();
      step(mk(OP_LW, 6'd0, 1'b0, 1'b1, 4'd0, W_FETCH_RDY), "rr fetch");
      step(mk(OP_LW, 6'd0, 1'b0, 1'b1, 4'd1, W_DECODE), "rr decode");
      step(mk(OP_LW, 6'd0, 1'b0, 1'b1, 4'd2, W_MEMADR), "rr memadr");
      step(mk(OP_LW, 6'd0, 1'b0, 1'b0, 4'd3, W_MEMREAD), "rr memread");
      reset = 1'b0;
      #1;
      chk("rr reset state", {28'b0, state}, 32'd0);
      chk("rr reset ctl", {14'b0, act_w}, {14'b0, W_FETCH_WAIT});
      #1 reset = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      step(mk(OP_LW, 6'd0, 1'b0, 1'b1, 4'd1, W_DECODE), "rr post edge");

      // R-type with unsupported funct halts
      do_reset();
      step(mk(OP_R, 6'b000000, 1'b0, 1'b1, 4'd0, W_FETCH_RDY), "badf fetch");
      step(mk(OP_R, 6'b000000, 1'b0, 1'b1, 4'd1, W_DECODE), "badf decode");
      step(mk(OP_R, 6'b000000, 1'b0, 1'b1, 4'd12, W_HALT), "badf halt");

      // bne: branch with inverted zero sense when enabled, otherwise unsupported
      do_reset();
`ifdef MULTICYCLE_CTRL_BNE_EN
      step(mk(OP_BNE, 6'd0, 1'b1, 1'b1, 4'd0, W_FETCH_RDY), "bne fetch");
      step(mk(OP_BNE, 6'd0, 1'b1, 1'b1, 4'd1, W_DECODE), "bne decode");
      step(mk(OP_BNE, 6'd0, 1'b1, 1'b1, 4'd8, W_BR_N), "bne z1");
      step(mk(OP_BNE, 6'd0, 1'b0, 1'b1, 4'd0, W_FETCH_RDY), "bne fetch2");
      step(mk(OP_BNE, 6'd0, 1'b0, 1'b1, 4'd1, W_DECODE), "bne decode2");
      step(mk(OP_BNE, 6'd0, 1'b0, 1'b1, 4'd8, W_BR_T), "bne z0");
`else
      step(mk(OP_BNE, 6'd0, 1'b0, 1'b1, 4'd0, W_FETCH_RDY), "bne fetch");
      step(mk(OP_BNE, 6'd0, 1'b0, 1'b1, 4'd1, W_DECODE), "bne decode");
      step(mk(OP_BNE, 6'd0, 1'b0, 1'b1, 4'd12, W_HALT), "bne halt");
`endif

      // TIMEOUT=0 instance: ready wins on the first cycle, any wait cycle halts
      do_reset();
      step(mk(OP_J, 6'd0, 1'b0, 1'b1, 4'd0, W_FETCH_RDY), "t0 fetch");
      chk("t0 decode state", {28'b0, z_state}, 32'd1);
      step(mk(OP_J, 6'd0, 1'b0, 1'b1, 4'd1, W_DECODE), "t0 decode");
      step(mk(OP_J, 6'd0, 1'b0, 1'b1, 4'd11, W_JUMP), "t0 jump");
      chk("t0 fetch state", {28'b0, z_state}, 32'd0);
      step(mk(OP_J, 6'd0, 1'b0, 1'b0, 4'd0, W_FETCH_WAIT), "t0 wait");
      chk("t0 halt state", {28'b0, z_state}, 32'd12);
      chk("t0 halt ctl", {14'b0, z_w}, {14'b0, W_HALT_ERR});
      chk("t0 main no err", {31'b0, bus_err}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
